// File: rtl/rom_seq_pkg.sv
// Shared definitions for the FIR test-signal ROM sequencer: table ids,
// table length lookup and FSM state encoding.
package rom_seq_pkg;

  localparam int unsigned TBL_W  = 3;
  localparam int unsigned LAST_W = 12;

  localparam logic [TBL_W-1:0] TBL_64   = 3'd0;
  localparam logic [TBL_W-1:0] TBL_128  = 3'd1;
  localparam logic [TBL_W-1:0] TBL_512  = 3'd2;
  localparam logic [TBL_W-1:0] TBL_2048 = 3'd3;
  localparam logic [TBL_W-1:0] TBL_4096 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic tbl_valid(input logic [TBL_W-1:0] id);
    return id <= TBL_4096;
  endfunction

  // Last valid index of each table; invalid ids map to 0.
  function automatic logic [LAST_W-1:0] tbl_last(input logic [TBL_W-1:0] id);
    case (id)
      TBL_64:   return 12'd63;
      TBL_128:  return 12'd127;
      TBL_512:  return 12'd511;
      TBL_2048: return 12'd2047;
      TBL_4096: return 12'd4095;
      default:  return 12'd0;
    endcase
  endfunction

endpackage

// File: rtl/rom_seq_tick.sv
// Sample-rate divider: counts 0..div_q while enabled and flags the tick
// cycle combinationally. div is captured on clr (start) or load (wrap).
module rom_seq_tick #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;

  assign tick_c = en && (cnt_q == div_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      if (clr || load) div_q <= div;
      if (clr || !en || tick_c) cnt_q <= '0;
      else                      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/rom_seq_ctrl.sv
// FIR test-signal ROM sequencer. Define ROM_SEQ_STOP_ALIGN_EN to make stop
// finish the current table period (DRAIN) instead of halting immediately.
module rom_seq_ctrl
  import rom_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [TBL_W-1:0]  tbl_sel,
  input  logic [DIV_W-1:0]  div,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  output logic [TBL_W-1:0]  tbl_act,
  output logic              smp_valid,
  output logic              wrap,
  output logic              busy,
  output logic              sel_err
);

  state_e state_q, state_d;
  logic accept_c, err_c, halt_c, en_c, load_c, tick_c;
  logic [ADDR_W-1:0] addr_d, last_c;
  logic [ROM_LAT-1:0] vld_q;

  assign last_c = ADDR_W'(tbl_last(tbl_act));
  // New table/rate only take effect at a period boundary.
  assign load_c = wrap && tbl_valid(tbl_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    err_c    = 1'b0;
    halt_c   = 1'b0;
    en_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (tbl_valid(tbl_sel)) begin
            accept_c = 1'b1;
            state_d  = ST_RUN;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      ST_RUN: begin
        en_c = 1'b1;
        if (stop) begin
`ifdef ROM_SEQ_STOP_ALIGN_EN
          state_d = ST_DRAIN;
`else
          en_c    = 1'b0;
          halt_c  = 1'b1;
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef ROM_SEQ_STOP_ALIGN_EN
      ST_DRAIN: begin
        if (wrap) begin
          halt_c  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          en_c = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  rom_seq_tick #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept_c),
    .load   (load_c),
    .en     (en_c),
    .div    (div),
    .tick_c (tick_c)
  );

  // Address advances the cycle after each read, wrapping at the table end.
  always_comb begin
    addr_d = rom_addr;
    if (accept_c || halt_c) addr_d = '0;
    else if (rom_en)        addr_d = (rom_addr == last_c) ? '0 : rom_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      rom_en   <= 1'b0;
      wrap     <= 1'b0;
      tbl_act  <= '0;
      sel_err  <= 1'b0;
      vld_q    <= '0;
    end else begin
      rom_addr <= addr_d;
      rom_en   <= tick_c;
      wrap     <= tick_c && (addr_d == last_c);
      if (accept_c || load_c) tbl_act <= tbl_sel;
      if (accept_c)   sel_err <= 1'b0;
      else if (err_c) sel_err <= 1'b1;
      vld_q[0] <= rom_en;
      for (int i = 1; i < ROM_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign smp_valid = vld_q[ROM_LAT-1];

endmodule

// File: doc/rom_seq_ctrl.md
Name: rom_seq_ctrl

Overview:
- Sequencer for the FIR test-signal ROM bank, which holds five sine tables of 64, 128, 512, 2048 and 4096 entries.
- Starts and stops playback, picks the active table and paces address generation with a programmable sample divider.
- Changes table and rate only on period boundaries, so the FIR input never glitches mid-period.
- Produces a data-valid strobe aligned to ROM read latency for the FIR input stage.

Parameters:
- ADDR_W, 12, address width; sized for the 4096-entry table.
- DIV_W, 8, width of the sample-rate divider.
- ROM_LAT, 1, ROM read latency in cycles (1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  level; begin playback when idle.
- stop  in  1  level; end playback.
- tbl_sel  in  3  requested table: 0=64, 1=128, 2=512, 3=2048, 4=4096; 5..7 invalid.
- div  in  DIV_W  requested divider; one sample every div+1 cycles.
- rom_addr  out  ADDR_W  table index.
- rom_en  out  1  ROM read enable; one-cycle pulse per sample.
- tbl_act  out  3  table in use; drives the ROM output mux.
- smp_valid  out  1  rom_en delayed by ROM_LAT cycles; marks ROM data valid.
- wrap  out  1  one-cycle pulse on the cycle rom_en reads the last index of the table.
- busy  out  1  high in RUN and DRAIN.
- sel_err  out  1  sticky; set when start is seen with an invalid tbl_sel; cleared by the next accepted start or by rst.

Behaviour:
- Reset (synchronous, on clk edge with rst=1): FSM=IDLE; rom_addr=0, rom_en=0, tbl_act=0, smp_valid=0 (all delay stages cleared), wrap=0, busy=0, sel_err=0, divider counter=0.
- States: IDLE, RUN, DRAIN (DRAIN exists only with the optional feature).
- IDLE, start=1, stop=0, tbl_sel<=4: latch tbl_sel into tbl_act, latch div, set rom_addr=0 and divider counter=0, go to RUN.
- IDLE, start with invalid tbl_sel: set sel_err, stay in IDLE.
- start and stop high in the same cycle: stop wins; stay in IDLE.
- RUN, divider counter: counts 0..div_latched. The tick occurs on the cycle the counter equals div_latched; the counter then returns to 0.
  - div=0: a tick every cycle.
  - div=1: a tick every 2nd cycle.
- First tick arrives div+1 cycles after entering RUN.
- On a tick:
  - rom_en=1 for that cycle, reading the current rom_addr.
  - The next cycle, rom_addr = rom_addr+1, or 0 if rom_addr = LEN-1, where LEN is the length of tbl_act.
  - wrap=1 on the tick cycle where rom_addr = LEN-1.
- Table/rate change:
  - tbl_sel and div are sampled only on a wrap tick.
  - If tbl_sel is valid, tbl_act and div_latched update on the following cycle.
  - If tbl_sel is invalid, the current values are kept and sel_err is not set.
- start while in RUN: ignored.
- Upper address bits above log2(LEN) are always 0.
- Stop in RUN (feature off): next cycle goes to IDLE; rom_addr=0, rom_en=0. smp_valid still drains the samples already issued.
- busy=1 in RUN and DRAIN, 0 in IDLE.
- smp_valid is a pure ROM_LAT-deep shift of rom_en and is independent of FSM state after stop.
- stop asserted in IDLE: no effect.

Optional Feature:
- Macro: ROM_SEQ_STOP_ALIGN_EN.
- Defined:
  - stop in RUN goes to DRAIN.
  - DRAIN keeps ticking until the wrap tick, then goes to IDLE, so the FIR always receives whole periods.
  - start is ignored in DRAIN.
  - rst still aborts immediately.
- Undefined: immediate stop as described in Behaviour; DRAIN is not synthesised.

Decomposition:
- Shared package rom_seq_pkg:
  - Table id constants TBL_64..TBL_4096.
  - LEN lookup function mapping table id to last index (63, 127, 511, 2047, 4095).
  - State encoding IDLE/RUN/DRAIN.
- Natural sub-module: rom_seq_tick, the divider counter with latched div, clear and tick outputs.
- FSM, address counter and valid delay line stay in the top.

Test Plan:
- Reset, then start with tbl_sel=0, div=1.
  - rom_en pulses every 2nd cycle; rom_addr runs 0..63.
  - wrap pulses with addr=63; the next read is addr=0.
  - smp_valid trails rom_en by ROM_LAT=1.
- tbl_sel changed 0->4 mid-period, div=0.
  - tbl_act stays 0 until the wrap at addr 63, then becomes 4.
  - Addresses run 0..4095, one per cycle.
- start with tbl_sel=6.
  - sel_err=1, busy=0, no rom_en.
  - A following start with tbl_sel=2 clears sel_err and runs 0..511.
- start=stop=1 in IDLE: stays in IDLE. stop at addr=100 in table 1 with the feature off: next cycle busy=0, rom_addr=0, and exactly ROM_LAT trailing smp_valid pulses.
- With ROM_SEQ_STOP_ALIGN_EN, table 1, div=0, stop at addr=100: reads continue to 127, wrap pulses, then IDLE; start during DRAIN is ignored.
- rst=1 pulsed mid-RUN at addr=2000 of table 3: all outputs 0 on the next edge, including the smp_valid pipeline; no spurious rom_en after rst drops.
